pll_drp_ctrl: RTL and testbench
===============================

// Module: pll_drp_ctrl
// PURPOSE
// - DRP initiator for a 7-series PLLE2_ADV/MMCM; drives DADDR/DEN/DWE/DI and consumes DO/DRDY/LOCKED.
// - Applies a host-supplied list of read-modify-write register updates with the PLL held in reset.
// - Releases the PLL reset, then waits for lock.
// - Sits beside clk_mgmt on the free-running input clock; that clock also drives the PLL DCLK.
// PARAMETERS
// - DRDY_TIMEOUT  64      max cycles from DEN pulse to DRDY before error (>=2)
// - LOCK_TIMEOUT  65535   max cycles in LOCK_WAIT before error (>=1)
// - SYNC_STAGES   2       flops on pll_locked_i synchroniser (>=2)
// PORTS
// - clk          in   1   DRP/control clock (same net as PLL DCLK)
// - arst_n       in   1   async reset, active-low
// - req_valid    in   1   update entry valid
// - req_ready    out  1   entry accepted when req_valid&req_ready
// - req_addr     in   7   DRP register address
// - req_mask     in   16  1 = keep existing bit, 0 = replace with req_data bit
// - req_data     in   16  new bit values
// - req_last     in   1   final entry of this reconfiguration
// - busy         out  1   high from first accept until done/err
// - done         out  1   1-cycle pulse: sequence finished and PLL locked
// - err          out  1   1-cycle pulse: DRDY or lock timeout (or readback mismatch)
// - locked       out  1   synchronised PLL lock, forced 0 while busy
// - drp_daddr    out  7   to PLL DADDR
// - drp_den      out  1   to PLL DEN
// - drp_dwe      out  1   to PLL DWE
// - drp_di       out  16  to PLL DI
// - drp_do       in   16  from PLL DO
// - drp_drdy     in   1   from PLL DRDY
// - pll_rst      out  1   to PLL RST
// - pll_locked_i in   1   from PLL LOCKED (async; synchronised)
// BEHAVIOUR
// - Reset values: all outputs 0 except req_ready = 1 (state IDLE); drp_daddr and drp_di = 0.
// - FSM: IDLE, RD, RD_WAIT, WR, WR_WAIT, NEXT, LOCK_WAIT.
// - IDLE: req_ready = 1. On accept, capture addr/mask/data/last, set pll_rst = 1 and busy = 1, go to RD.
// - RD: drp_den = 1 and drp_dwe = 0 for exactly 1 cycle, drp_daddr = addr, go to RD_WAIT.
// - RD_WAIT: on drp_drdy, merged = (drp_do & mask) | (data & ~mask), registered; go to WR.
// - WR: drp_den = drp_dwe = 1 for 1 cycle, drp_di = merged; go to WR_WAIT.
// - WR_WAIT: on drp_drdy, go to LOCK_WAIT if last, else NEXT.
// - NEXT: req_ready = 1. On accept, capture the entry and go to RD. pll_rst stays 1; there is no limit on the wait.
// - LOCK_WAIT: pll_rst = 0 from the first cycle. Synced lock = 1 -> done pulse, busy = 0, IDLE.
// - Lock latency: done rises SYNC_STAGES+1 cycles after pll_locked_i rises at the earliest.
// - A lock already high on entry does not count: the synced lock must be seen 0 at least once in LOCK_WAIT first.
// - DRP rules: at most one DEN outstanding. A DRDY arriving outside RD_WAIT/WR_WAIT is ignored.
// - DRP address/data are held stable until DRDY.
// - Timeouts: a counter restarts on each DEN.
//   - DRDY_TIMEOUT cycles without DRDY -> err pulse, pll_rst = 0, busy = 0, IDLE.
//   - LOCK_TIMEOUT cycles in LOCK_WAIT without lock -> same exit.
// - Earliest throughput: entry accept -> next req_ready is 5 cycles when DRDY returns 1 cycle after DEN.
// - req_ready is never high in RD..WR_WAIT or LOCK_WAIT. req_valid there is held by the host (valid/ready rule).
// - done and err are mutually exclusive and never fire in the same cycle as an accept.
// - arst_n low mid-sequence: immediate return to reset values; pll_rst drops to 0.
//   - The PLL then relocks with partial register contents; the host must re-issue the full list.
// CONFIGURATION
// - PLL_DRP_READBACK_EN defined:
//   - After WR_WAIT, do an extra RD/RD_WAIT of the same address.
//   - drp_do != merged -> err pulse and the timeout-style exit.
//   - Match -> continue as normal (NEXT or LOCK_WAIT).
// - Not defined: no readback states; WR_WAIT goes directly to NEXT/LOCK_WAIT.
// TESTING
// - Single entry addr=7'h08, mask=16'hF000, data=16'h0145, DRP model returns DO=16'hA3C7:
//   -> write DI=16'hA145; pll_rst high from accept until WR_WAIT exit; done after lock.
// - Three entries (7'h08, 7'h09, 7'h14, last on third), host inserts 10 idle cycles between entries:
//   -> pll_rst stays 1 across NEXT; exactly 3 writes; one done.
// - DRP model never asserts DRDY:
//   -> err exactly DRDY_TIMEOUT cycles after DEN; pll_rst = 0; back in IDLE with req_ready = 1.
// - pll_locked_i stuck 1 throughout:
//   -> no done (no 0 observed); err after LOCK_TIMEOUT. With LOCK_TIMEOUT = 100, err at cycle 100 of LOCK_WAIT.
// - arst_n pulsed low during WR_WAIT:
//   -> all outputs at reset values asynchronously; a stale DRDY after reset is ignored.
// - PLL_DRP_READBACK_EN, model corrupts readback to 16'h0000:
//   -> err pulse, no done; without the macro the same stimulus gives done.

Source files
------------

// File: rtl/pll_drp_ctrl.sv
// DRP read-modify-write sequencer for a 7-series PLL/MMCM: holds the PLL in reset while
// applying host entries, then releases it and waits for relock. Define PLL_DRP_READBACK_EN for write verify.
module pll_drp_ctrl #(
  parameter int DRDY_TIMEOUT = 64,
  parameter int LOCK_TIMEOUT = 65535,
  parameter int SYNC_STAGES  = 2
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [6:0]  req_addr,
  input  logic [15:0] req_mask,
  input  logic [15:0] req_data,
  input  logic        req_last,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        locked,
  output logic [6:0]  drp_daddr,
  output logic        drp_den,
  output logic        drp_dwe,
  output logic [15:0] drp_di,
  input  logic [15:0] drp_do,
  input  logic        drp_drdy,
  output logic        pll_rst,
  input  logic        pll_locked_i
);
  localparam int TMAX = (DRDY_TIMEOUT > LOCK_TIMEOUT) ? DRDY_TIMEOUT : LOCK_TIMEOUT;
  localparam int CW   = $clog2(TMAX + 1);

  typedef enum logic [3:0] {
    IDLE, RD, RD_WAIT, WR, WR_WAIT, NEXT, LOCK_WAIT
`ifdef PLL_DRP_READBACK_EN
    , RB, RB_WAIT
`endif
  } state_e;

  typedef struct packed {
    logic [6:0]  addr;
    logic [15:0] mask;
    logic [15:0] data;
    logic        last;
  } req_t;

  state_e                 state_q, state_d;
  req_t                   req_q, req_d;
  logic [15:0]            merged_q, merged_d;
  logic [CW-1:0]          cnt_q, cnt_d, tmo_lim;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_q, seen0_q, seen0_d;
  logic                   in_wait, tmo;

  // Extra lock_q stage after the synchroniser keeps done at least SYNC_STAGES+1 cycles behind LOCKED.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sync_q <= '0;
      lock_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked_i};
      lock_q <= sync_q[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q  <= IDLE;
      req_q    <= '0;
      merged_q <= '0;
      cnt_q    <= '0;
      seen0_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      merged_q <= merged_d;
      cnt_q    <= cnt_d;
      seen0_q  <= seen0_d;
    end
  end

  assign tmo_lim = (state_q == LOCK_WAIT) ? CW'(LOCK_TIMEOUT - 1) : CW'(DRDY_TIMEOUT - 1);
  assign tmo     = (cnt_q == tmo_lim);

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    merged_d  = merged_q;
    req_ready = 1'b0;
    drp_den   = 1'b0;
    drp_dwe   = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    pll_rst   = 1'b1;
    in_wait   = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        pll_rst   = 1'b0;
        if (req_valid) begin
          req_d   = {req_addr, req_mask, req_data, req_last};
          state_d = RD;
        end
      end
      RD: begin
        drp_den = 1'b1;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        in_wait = 1'b1;
        if (drp_drdy) begin
          merged_d = (drp_do & req_q.mask) | (req_q.data & ~req_q.mask);
          state_d  = WR;
        end else if (tmo) begin
          err     = 1'b1;
          state_d = IDLE;
        end
      end
      WR: begin
        drp_den = 1'b1;
        drp_dwe = 1'b1;
        state_d = WR_WAIT;
      end
      WR_WAIT: begin
        in_wait = 1'b1;
        if (drp_drdy) begin
`ifdef PLL_DRP_READBACK_EN
          state_d = RB;
`else
          if (req_q.last) state_d = LOCK_WAIT;
          else            state_d = NEXT;
`endif
        end else if (tmo) begin
          err     = 1'b1;
          state_d = IDLE;
        end
      end
`ifdef PLL_DRP_READBACK_EN
      RB: begin
        drp_den = 1'b1;
        state_d = RB_WAIT;
      end
      RB_WAIT: begin
        in_wait = 1'b1;
        if (drp_drdy) begin
          if (drp_do != merged_q) begin
            err     = 1'b1;
            state_d = IDLE;
          end else if (req_q.last) state_d = LOCK_WAIT;
          else                     state_d = NEXT;
        end else if (tmo) begin
          err     = 1'b1;
          state_d = IDLE;
        end
      end
`endif
      NEXT: begin
        req_ready = 1'b1;
        if (req_valid) begin
          req_d   = {req_addr, req_mask, req_data, req_last};
          state_d = RD;
        end
      end
      LOCK_WAIT: begin
        pll_rst = 1'b0;
        in_wait = 1'b1;
        if (seen0_q && lock_q) begin
          done    = 1'b1;
          state_d = IDLE;
        end else if (tmo) begin
          err     = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Timeout counter restarts on every state change, so it measures time since DEN / LOCK_WAIT entry.
    cnt_d = '0;
    if (in_wait && (state_d == state_q)) cnt_d = cnt_q + CW'(1);
    // A lock already high on entry must drop once before it counts.
    seen0_d = (state_q == LOCK_WAIT) && (seen0_q || !lock_q);
  end

  assign busy      = (state_q != IDLE);
  assign locked    = lock_q & ~busy;
  assign drp_daddr = req_q.addr;
  assign drp_di    = merged_q;

endmodule

// File: tb/tb_pll_drp_ctrl.sv
// Bench for pll_drp_ctrl: DRP register model, PLL lock model and a write scoreboard.
module tb_pll_drp_ctrl;
  localparam int DRDY_TO = 16;
  localparam int LOCK_TO = 100;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        req_valid, req_ready, req_last;
  logic [6:0]  req_addr;
  logic [15:0] req_mask, req_data;
  logic        busy, done, err, locked;
  logic [6:0]  drp_daddr;
  logic        drp_den, drp_dwe;
  logic [15:0] drp_di;
  logic [15:0] drp_do = 16'h0;
  logic        drp_drdy = 1'b0;
  logic        pll_rst, pll_locked_i;

  pll_drp_ctrl #(.DRDY_TIMEOUT(DRDY_TO), .LOCK_TIMEOUT(LOCK_TO), .SYNC_STAGES(2)) dut (
    .clk(clk), .arst_n(arst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_mask(req_mask), .req_data(req_data), .req_last(req_last),
    .busy(busy), .done(done), .err(err), .locked(locked),
    .drp_daddr(drp_daddr), .drp_den(drp_den), .drp_dwe(drp_dwe), .drp_di(drp_di),
    .drp_do(drp_do), .drp_drdy(drp_drdy),
    .pll_rst(pll_rst), .pll_locked_i(pll_locked_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // DRP register model: reads return the initial contents unless a read directly follows a write
  // to the same address (readback), which may be corrupted on request.
  logic [15:0] init_mem [0:127];
  logic [15:0] rd_val, last_wr = 16'h0;
  logic [6:0]  last_a = 7'h0;
  logic        after_wr = 1'b0;
  int          drdy_lat, pend = 0;
  logic [15:0] pend_do = 16'h0;
  bit          drdy_dead, corrupt;
  logic [22:0] obs_q[$];
  logic [22:0] exp_q[$];

  assign rd_val = (after_wr && drp_daddr == last_a) ? (corrupt ? 16'h0000 : last_wr)
                                                    : init_mem[drp_daddr];

  always @(posedge clk) begin
    drp_drdy <= 1'b0;
    if (pend > 0) begin
      pend <= pend - 1;
      if (pend == 1) begin
        drp_drdy <= 1'b1;
        drp_do   <= pend_do;
      end
    end
    if (drp_den) begin
      if (drp_dwe) begin
        after_wr <= 1'b1;
        last_a   <= drp_daddr;
        last_wr  <= drp_di;
        obs_q.push_back({drp_daddr, drp_di});
      end else begin
        after_wr <= 1'b0;
      end
      if (!drdy_dead) begin
        if (drdy_lat <= 1) begin
          drp_drdy <= 1'b1;
          drp_do   <= drp_dwe ? 16'h0 : rd_val;
        end else begin
          pend    <= drdy_lat - 1;
          pend_do <= drp_dwe ? 16'h0 : rd_val;
        end
      end
    end
  end

  // PLL lock model: loses lock under reset, regains it 8 cycles after release (or stuck high).
  int lcnt = 0;
  bit lock_stuck;
  always @(posedge clk) begin
    if (pll_rst)        lcnt <= 0;
    else if (lcnt < 8)  lcnt <= lcnt + 1;
  end
  assign pll_locked_i = lock_stuck || (lcnt >= 8);

  typedef struct {
    logic [6:0]  addr;
    logic [15:0] mask;
    logic [15:0] data;
    logic [15:0] dout;
    logic [15:0] exp_di;
  } vec_t;
  vec_t vecs[6];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ref_merge(input logic [15:0] dout, mask, data);
    return (dout & mask) | (data & ~mask);
  endfunction

  task automatic send(input logic [6:0] a, input logic [15:0] m, input logic [15:0] d, input bit last);
    int n = 0;
    req_valid = 1'b1; req_addr = a; req_mask = m; req_data = d; req_last = last;
    while (!req_ready && n < 200) begin tick(); n++; end
    if (n >= 200) check("send_ready_timeout", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_end(output bit gd, output bit ge, output int n);
    gd = 0; ge = 0; n = 0;
    while (!gd && !ge && n < 600) begin
      tick(); n++;
      gd = done; ge = err;
    end
  endtask

  task automatic sb_check(input string name);
    int i = 0;
    while (obs_q.size() > 0) begin
      logic [22:0] o;
      o = obs_q.pop_front();
      if (exp_q.size() == 0) check({name, "_unexpected"}, 32'(o), 32'h0);
      else check($sformatf("%s_%0d", name, i), 32'(o), 32'(exp_q.pop_front()));
      i++;
    end
    check({name, "_missing"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    bit gd, ge;
    int n, bad, k;
    logic [15:0] e;

    vecs[0] = '{7'h08, 16'hF000, 16'h0145, 16'hA3C7, 16'hA145};
    vecs[1] = '{7'h7F, 16'hFFFF, 16'h1234, 16'hBEEF, 16'hBEEF};
    vecs[2] = '{7'h00, 16'h0000, 16'h1234, 16'hBEEF, 16'h1234};
    vecs[3] = '{7'h2A, 16'h00FF, 16'hABCD, 16'h5566, 16'hAB66};
    vecs[4] = '{7'h15, 16'h5555, 16'hFFFF, 16'h0000, 16'hAAAA};
    vecs[5] = '{7'h40, 16'hAAAA, 16'h0000, 16'hF0F0, 16'hA0A0};

    for (int i = 0; i < 128; i++) init_mem[i] = 16'h0;
    arst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_mask = '0; req_data = '0; req_last = 1'b0;
    drdy_lat = 1; drdy_dead = 0; corrupt = 0; lock_stuck = 0;

    repeat (3) tick();
    check("rst_ctrl", {req_ready, busy, done, err, locked, drp_den, drp_dwe, pll_rst}, 8'b1000_0000);
    check("rst_drp", {drp_daddr, drp_di}, 23'h0);
    arst_n = 1'b1;
    repeat (12) tick();

    // Single-entry reconfigurations from the vector table.
    for (int v = 0; v < 6; v++) begin
      init_mem[vecs[v].addr] = vecs[v].dout;
      send(vecs[v].addr, vecs[v].mask, vecs[v].data, 1'b1);
      exp_q.push_back({vecs[v].addr, vecs[v].exp_di});
      check($sformatf("v%0d_rd", v), {pll_rst, busy, drp_den, drp_dwe, locked}, 5'b11100);
      wait_end(gd, ge, n);
      check($sformatf("v%0d_done", v), {gd, ge}, 2'b10);
      tick();
      check($sformatf("v%0d_idle", v), {busy, pll_rst, req_ready, locked, done}, 5'b00110);
      sb_check($sformatf("v%0d_di", v));
      repeat (4) tick();
    end

    // Three entries with idle gaps: rst held across NEXT, one done.
    init_mem[7'h09] = 16'h0F0F;
    init_mem[7'h14] = 16'h1234;
    send(7'h08, 16'hFF00, 16'h0011, 1'b0);
    exp_q.push_back({7'h08, ref_merge(16'hA3C7, 16'hFF00, 16'h0011)});
    n = 1;
    while (!req_ready && n < 50) begin tick(); n++; end
`ifdef PLL_DRP_READBACK_EN
    check("thru", n, 7);
`else
    check("thru", n, 5);
`endif
    bad = 0;
    repeat (10) begin tick(); if (!(pll_rst && busy && req_ready)) bad++; end
    check("gap1_rst", bad, 0);
    send(7'h09, 16'h0000, 16'h5A5A, 1'b0);
    exp_q.push_back({7'h09, ref_merge(16'h0F0F, 16'h0000, 16'h5A5A)});
    n = 0;
    while (!req_ready && n < 50) begin tick(); n++; end
    bad = 0;
    repeat (10) begin tick(); if (!(pll_rst && busy && req_ready)) bad++; end
    check("gap2_rst", bad, 0);
    send(7'h14, 16'hFFF0, 16'h0007, 1'b1);
    exp_q.push_back({7'h14, ref_merge(16'h1234, 16'hFFF0, 16'h0007)});
    wait_end(gd, ge, n);
    check("3e_done", {gd, ge}, 2'b10);
    k = 0;
    repeat (6) begin tick(); if (done) k++; end
    check("3e_extra_done", k, 0);
    check("3e_writes", obs_q.size(), 3);
    sb_check("3e_di");

    // DRDY never returns.
    drdy_dead = 1;
    send(7'h30, 16'h0000, 16'h1111, 1'b1);
    check("to_den", {drp_den, drp_dwe}, 2'b10);
    n = 0; ge = 0;
    while (!ge && n < 200) begin tick(); n++; ge = err; end
    check("to_cycles", n, DRDY_TO);
    tick();
    check("to_exit", {err, pll_rst, busy, req_ready}, 4'b0001);
    drdy_dead = 0;
    sb_check("to_wr");
    repeat (12) tick();

    // Async reset during WR_WAIT, then a stale DRDY.
    drdy_lat = 6;
    init_mem[7'h21] = 16'h1357;
    send(7'h21, 16'h0000, 16'h9ABC, 1'b1);
    exp_q.push_back({7'h21, 16'h9ABC});
    n = 0;
    while (!(drp_den && drp_dwe) && n < 100) begin tick(); n++; end
    tick();
    check("ar_pre", {busy, pll_rst, drp_di}, {2'b11, 16'h9ABC});
    arst_n = 1'b0;
    #1;
    check("ar_ctrl", {req_ready, busy, done, err, locked, drp_den, drp_dwe, pll_rst}, 8'b1000_0000);
    check("ar_drp", {drp_daddr, drp_di}, 23'h0);
    #2 arst_n = 1'b1;
    bad = 0;
    repeat (10) begin tick(); if (busy || drp_den || done || err || !req_ready) bad++; end
    check("stale_drdy", bad, 0);
    drdy_lat = 1;
    sb_check("ar_wr");
    repeat (12) tick();

    // Lock stuck high: no done, err on cycle LOCK_TO of LOCK_WAIT.
    lock_stuck = 1;
    repeat (4) tick();
    send(7'h31, 16'hFFFF, 16'h0000, 1'b1);
    exp_q.push_back({7'h31, 16'h0000});
    n = 0;
    while (!(busy && !pll_rst) && n < 100) begin tick(); n++; end
    k = 1; gd = 0;
    while (!err && k < 400) begin
      if (done) gd = 1;
      tick(); k++;
    end
    check("lk_cycles", k, LOCK_TO);
    check("lk_nodone", gd, 0);
    lock_stuck = 0;
    sb_check("lk_wr");
    repeat (12) tick();

    // Readback corruption.
    corrupt = 1;
    init_mem[7'h33] = 16'h1111;
    send(7'h33, 16'h0000, 16'h2222, 1'b1);
    exp_q.push_back({7'h33, 16'h2222});
    wait_end(gd, ge, n);
`ifdef PLL_DRP_READBACK_EN
    check("rb_result", {gd, ge}, 2'b01);
`else
    check("rb_result", {gd, ge}, 2'b10);
`endif
    tick();
    check("rb_exit", {busy, pll_rst, req_ready}, 3'b001);
    corrupt = 0;
    sb_check("rb_wr");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
